// File: rtl/gpio_ctrl_gen2_pkg.sv
// -----------------------------------------------------------------------------
// gpio_ctrl_gen2_pkg
// Shared definitions for the GPIO controller: APB register byte offsets,
// register reset values, the debounce sample count and the address decoder
// that maps a byte address onto a register select.
// -----------------------------------------------------------------------------
package gpio_ctrl_gen2_pkg;

   // Register byte offsets (paddr[1:0] are ignored by the decoder)
   localparam logic [5:0] OFF_DOUT  = 6'h00;
   localparam logic [5:0] OFF_DIR   = 6'h04;
   localparam logic [5:0] OFF_DIN   = 6'h08;
   localparam logic [5:0] OFF_IEN   = 6'h0C;
   localparam logic [5:0] OFF_ITYPE = 6'h10;
   localparam logic [5:0] OFF_IPOL  = 6'h14;
   localparam logic [5:0] OFF_ISTAT = 6'h18;
   localparam logic [5:0] OFF_IBOTH = 6'h1C;
   localparam logic [5:0] OFF_DBPRE = 6'h20;

   // Reset values
   localparam logic [31:0] RST_REG   = 32'h0000_0000;
   localparam logic [15:0] RST_DBPRE = 16'h0000;

   // Consecutive equal tick samples needed before a debounced pin follows
   localparam int DEB_SAMPLES = 3;

   typedef enum logic [3:0] {
      SEL_DOUT,
      SEL_DIR,
      SEL_DIN,
      SEL_IEN,
      SEL_ITYPE,
      SEL_IPOL,
      SEL_ISTAT,
      SEL_IBOTH,
      SEL_DBPRE,
      SEL_NONE
   } reg_sel_e;

   // Map a byte address onto a register select; unmapped words give SEL_NONE
   function automatic reg_sel_e decode_addr(input logic [5:0] addr);
      reg_sel_e sel;
      case (addr[5:2])
         OFF_DOUT[5:2]:  sel = SEL_DOUT;
         OFF_DIR[5:2]:   sel = SEL_DIR;
         OFF_DIN[5:2]:   sel = SEL_DIN;
         OFF_IEN[5:2]:   sel = SEL_IEN;
         OFF_ITYPE[5:2]: sel = SEL_ITYPE;
         OFF_IPOL[5:2]:  sel = SEL_IPOL;
         OFF_ISTAT[5:2]: sel = SEL_ISTAT;
         OFF_IBOTH[5:2]: sel = SEL_IBOTH;
         OFF_DBPRE[5:2]: sel = SEL_DBPRE;
         default:        sel = SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/gpio_ctrl_gen2_deb.sv
// -----------------------------------------------------------------------------
// gpio_ctrl_gen2_deb
// Single-pin debounce filter. On every prescaler tick the synchronised pin is
// sampled; the filtered output only follows once DEB_SAMPLES consecutive tick
// samples agree.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset (clears history and output)
//   tick      - shared prescaler strobe, one cycle wide
//   sample_in - synchronised pin value
//   filt_out  - debounced pin value (registered)
// -----------------------------------------------------------------------------
module gpio_ctrl_gen2_deb
   import gpio_ctrl_gen2_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic sample_in,
   output logic filt_out
);

   // Only the previous DEB_SAMPLES-1 samples are stored; the current input
   // completes the window.
   logic [DEB_SAMPLES-2:0] hist_r;
   logic [DEB_SAMPLES-1:0] window_s;
   logic                   filt_r;

   // Sample window formed from stored history plus the live sample
   always_comb begin
      window_s = {hist_r, sample_in};
   end

   // History shift and filtered output update on prescaler ticks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_r <= {(DEB_SAMPLES-1){1'b0}};
         filt_r <= 1'b0;
      end else if (tick) begin
         hist_r <= window_s[DEB_SAMPLES-2:0];
         if (&window_s) begin
            filt_r <= 1'b1;
         end else if (~|window_s) begin
            filt_r <= 1'b0;
         end else begin
            filt_r <= filt_r;
         end
      end else begin
         hist_r <= hist_r;
         filt_r <= filt_r;
      end
   end

   assign filt_out = filt_r;

endmodule

// File: rtl/gpio_ctrl_gen2.sv
// -----------------------------------------------------------------------------
// gpio_ctrl_gen2
// APB-programmable GPIO block: output data/direction, synchronised inputs and
// per-pin interrupts (level or edge, selectable polarity, both-edge option,
// write-1-to-clear status, registered interrupt line).
// Optional feature: define GPIO_CTRL_GEN2_DEBOUNCE_EN to add the DBPRE
// register (0x20) and a per-pin debounce filter after the synchroniser.
// Ports:
//   pclk, p_reset            - clock and asynchronous active-high reset
//   psel, penable, pwrite    - APB control
//   paddr[5:0], pwdata[31:0] - APB address / write data
//   prdata[31:0]             - APB read data (combinational)
//   gpio_pin_in              - asynchronous pin inputs
//   tri_state_enable         - DFT override, forces drivers off
//   gpio_pin_out             - pin drive values
//   n_gpio_pin_oe            - active-low output enables
//   gpio_int                 - registered interrupt
// -----------------------------------------------------------------------------
module gpio_ctrl_gen2
   import gpio_ctrl_gen2_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             pclk,
   input  logic             p_reset,
   input  logic             psel,
   input  logic             penable,
   input  logic             pwrite,
   input  logic [5:0]       paddr,
   input  logic [31:0]      pwdata,
   output logic [31:0]      prdata,
   input  logic [WIDTH-1:0] gpio_pin_in,
   input  logic [WIDTH-1:0] tri_state_enable,
   output logic [WIDTH-1:0] gpio_pin_out,
   output logic [WIDTH-1:0] n_gpio_pin_oe,
   output logic             gpio_int
);

   logic [WIDTH-1:0] dout_r;
   logic [WIDTH-1:0] dir_r;
   logic [WIDTH-1:0] ien_r;
   logic [WIDTH-1:0] itype_r;
   logic [WIDTH-1:0] ipol_r;
   logic [WIDTH-1:0] istat_r;
   logic [WIDTH-1:0] iboth_r;
   logic [WIDTH-1:0] prev_r;
   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic             gpio_int_r;

   logic [WIDTH-1:0] filt_s;
   logic [WIDTH-1:0] rise_s;
   logic [WIDTH-1:0] fall_s;
   logic [WIDTH-1:0] set_s;
   logic [WIDTH-1:0] clr_s;
   logic [WIDTH-1:0] wdata_s;
   logic [31:0]      rdata_s;
   logic             wr_en_s;
   reg_sel_e         sel_s;

   // Address bits [1:0] and data bits above WIDTH carry no information
   logic unused_s;
   assign unused_s = &{1'b0, paddr[1:0], pwdata};

   assign wr_en_s = psel & penable & pwrite;
   assign sel_s   = decode_addr(paddr);
   assign wdata_s = pwdata[WIDTH-1:0];

   // Input synchroniser chain
   always_ff @(posedge pclk or posedge p_reset) begin
      if (p_reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= RST_REG[WIDTH-1:0];
         end
      end else begin
         sync_r[0] <= gpio_pin_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

`ifdef GPIO_CTRL_GEN2_DEBOUNCE_EN
   logic [15:0] dbpre_r;
   logic [15:0] pre_cnt_r;
   logic        tick_s;

   // ">=" keeps the tick period sane if DBPRE is lowered mid-count
   assign tick_s = (pre_cnt_r >= dbpre_r);

   // Debounce prescaler register
   always_ff @(posedge pclk or posedge p_reset) begin
      if (p_reset) begin
         dbpre_r <= RST_DBPRE;
      end else if (wr_en_s && (sel_s == SEL_DBPRE)) begin
         dbpre_r <= pwdata[15:0];
      end else begin
         dbpre_r <= dbpre_r;
      end
   end

   // Shared prescaler: one tick every DBPRE+1 cycles
   always_ff @(posedge pclk or posedge p_reset) begin
      if (p_reset) begin
         pre_cnt_r <= 16'h0000;
      end else if (tick_s) begin
         pre_cnt_r <= 16'h0000;
      end else begin
         pre_cnt_r <= pre_cnt_r + 16'h0001;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_deb
      gpio_ctrl_gen2_deb u_deb (
         .clk       (pclk),
         .rst       (p_reset),
         .tick      (tick_s),
         .sample_in (sync_r[SYNC_STAGES-1][g]),
         .filt_out  (filt_s[g])
      );
   end
`else
   assign filt_s = sync_r[SYNC_STAGES-1];
`endif

   // Control registers (ISTAT is handled separately)
   always_ff @(posedge pclk or posedge p_reset) begin
      if (p_reset) begin
         dout_r  <= RST_REG[WIDTH-1:0];
         dir_r   <= RST_REG[WIDTH-1:0];
         ien_r   <= RST_REG[WIDTH-1:0];
         itype_r <= RST_REG[WIDTH-1:0];
         ipol_r  <= RST_REG[WIDTH-1:0];
         iboth_r <= RST_REG[WIDTH-1:0];
      end else if (wr_en_s) begin
         case (sel_s)
            SEL_DOUT:  dout_r  <= wdata_s;
            SEL_DIR:   dir_r   <= wdata_s;
            SEL_IEN:   ien_r   <= wdata_s;
            SEL_ITYPE: itype_r <= wdata_s;
            SEL_IPOL:  ipol_r  <= wdata_s;
            SEL_IBOTH: iboth_r <= wdata_s;
            default:   ;
         endcase
      end else begin
         dout_r <= dout_r;
      end
   end

   // Interrupt source detection; prev tracks the filtered value one cycle late
   always_comb begin
      rise_s = filt_s & ~prev_r;
      fall_s = ~filt_s & prev_r;
      set_s  = (itype_r & ((iboth_r & (rise_s | fall_s)) |
                           (~iboth_r & ((ipol_r & rise_s) | (~ipol_r & fall_s))))) |
               (~itype_r & ~(filt_s ^ ipol_r));
      if (wr_en_s && (sel_s == SEL_ISTAT)) begin
         clr_s = wdata_s;
      end else begin
         clr_s = {WIDTH{1'b0}};
      end
   end

   // ISTAT with set-over-clear priority, previous-value and interrupt registers
   always_ff @(posedge pclk or posedge p_reset) begin
      if (p_reset) begin
         istat_r    <= RST_REG[WIDTH-1:0];
         prev_r     <= RST_REG[WIDTH-1:0];
         gpio_int_r <= 1'b0;
      end else begin
         istat_r    <= (istat_r & ~clr_s) | set_s;
         prev_r     <= filt_s;
         gpio_int_r <= |(istat_r & ien_r);
      end
   end

   // APB read mux, zero outside a read access
   always_comb begin
      rdata_s = 32'h0000_0000;
      if (psel && !pwrite) begin
         case (sel_s)
            SEL_DOUT:  rdata_s = 32'(dout_r);
            SEL_DIR:   rdata_s = 32'(dir_r);
            SEL_DIN:   rdata_s = 32'(filt_s);
            SEL_IEN:   rdata_s = 32'(ien_r);
            SEL_ITYPE: rdata_s = 32'(itype_r);
            SEL_IPOL:  rdata_s = 32'(ipol_r);
            SEL_ISTAT: rdata_s = 32'(istat_r);
            SEL_IBOTH: rdata_s = 32'(iboth_r);
`ifdef GPIO_CTRL_GEN2_DEBOUNCE_EN
            SEL_DBPRE: rdata_s = {16'h0000, dbpre_r};
`endif
            default:   rdata_s = 32'h0000_0000;
         endcase
      end else begin
         rdata_s = 32'h0000_0000;
      end
   end

   assign prdata        = rdata_s;
   assign gpio_pin_out  = dout_r;
   assign n_gpio_pin_oe = ~(dir_r & ~tri_state_enable);
   assign gpio_int      = gpio_int_r;

endmodule

// File: tb/tb_gpio_ctrl_gen2.sv
// -----------------------------------------------------------------------------
// tb_gpio_ctrl_gen2
// Self-checking bench: a 16-pin instance plus an 8-pin instance sharing the
// APB bus. Register accesses come from a vector table; interrupt latency,
// clear priority, reset behaviour and debounce use hand-written sequences.
// Expected values travel through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_gpio_ctrl_gen2;

   localparam int SYNC_STAGES = 2;
`ifdef GPIO_CTRL_GEN2_DEBOUNCE_EN
   // filter needs 3 tick samples (DBPRE=0: one tick per cycle)
   localparam int LAT = SYNC_STAGES + 1 + 3;
`else
   localparam int LAT = SYNC_STAGES + 1;
`endif

   logic        pclk;
   logic        p_reset;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [5:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic [31:0] prdata8;
   logic [15:0] gpio_pin_in;
   logic [15:0] tse;
   logic [15:0] pin_out;
   logic [15:0] n_oe;
   logic        gpio_int;
   logic [7:0]  pin_out8;
   logic [7:0]  n_oe8;
   logic        gpio_int8;

   gpio_ctrl_gen2 #(.WIDTH(16), .SYNC_STAGES(SYNC_STAGES)) u_dut (
      .pclk             (pclk),
      .p_reset          (p_reset),
      .psel             (psel),
      .penable          (penable),
      .pwrite           (pwrite),
      .paddr            (paddr),
      .pwdata           (pwdata),
      .prdata           (prdata),
      .gpio_pin_in      (gpio_pin_in),
      .tri_state_enable (tse),
      .gpio_pin_out     (pin_out),
      .n_gpio_pin_oe    (n_oe),
      .gpio_int         (gpio_int)
   );

   gpio_ctrl_gen2 #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES)) u_dut8 (
      .pclk             (pclk),
      .p_reset          (p_reset),
      .psel             (psel),
      .penable          (penable),
      .pwrite           (pwrite),
      .paddr            (paddr),
      .pwdata           (pwdata),
      .prdata           (prdata8),
      .gpio_pin_in      (gpio_pin_in[7:0]),
      .tri_state_enable (tse[7:0]),
      .gpio_pin_out     (pin_out8),
      .n_gpio_pin_oe    (n_oe8),
      .gpio_int         (gpio_int8)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // ---------------- scoreboard ----------------
   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  checks = 0;
   int  errors = 0;

   task automatic sb_push(input string n, input logic [31:0] e);
      sb_t item;
      item.name = n;
      item.exp  = e;
      sb_q.push_back(item);
   endtask

   task automatic sb_check(input logic [31:0] act);
      sb_t item;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty actual=%h", act);
      end else begin
         item = sb_q.pop_front();
         if (act !== item.exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", item.name, act, item.exp);
         end
      end
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
      sb_push(n, e);
      sb_check(act);
   endtask

   // ---------------- bus tasks ----------------
   task automatic bus_idle();
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 6'h00;
      pwdata  = 32'h0000_0000;
   endtask

   task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
      @(negedge pclk);
      paddr   = a;
      pwdata  = d;
      pwrite  = 1'b1;
      psel    = 1'b1;
      penable = 1'b0;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      bus_idle();
   endtask

   task automatic apb_read(input logic [5:0] a, output logic [31:0] d16, output logic [31:0] d8);
      @(negedge pclk);
      paddr   = a;
      pwrite  = 1'b0;
      psel    = 1'b1;
      penable = 1'b0;
      #2;
      d16 = prdata;
      d8  = prdata8;
      bus_idle();
   endtask

   task automatic do_reset();
      @(negedge pclk);
      bus_idle();
      gpio_pin_in = 16'h0000;
      tse         = 16'h0000;
      p_reset     = 1'b1;
      @(negedge pclk);
      p_reset = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [5:0]  wr_addr;
      logic [31:0] wr_data;
      logic [5:0]  rd_addr;
      logic [31:0] exp16;
      logic [31:0] exp8;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs [NVEC];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] r16;
      logic [31:0] r8;

      vecs[0]  = '{6'h00, 32'hFFFF_FFFF, 6'h00, 32'h0000_FFFF, 32'h0000_00FF};
      vecs[1]  = '{6'h04, 32'h1234_5678, 6'h04, 32'h0000_5678, 32'h0000_0078};
      vecs[2]  = '{6'h0C, 32'h0000_A5C3, 6'h0C, 32'h0000_A5C3, 32'h0000_00C3};
      vecs[3]  = '{6'h10, 32'hFFFF_0FF0, 6'h10, 32'h0000_0FF0, 32'h0000_00F0};
      vecs[4]  = '{6'h14, 32'h0000_00F0, 6'h14, 32'h0000_00F0, 32'h0000_00F0};
      vecs[5]  = '{6'h1C, 32'h8001_0F0F, 6'h1C, 32'h0000_0F0F, 32'h0000_000F};
      vecs[6]  = '{6'h3C, 32'hFFFF_FFFF, 6'h3C, 32'h0000_0000, 32'h0000_0000};
      vecs[7]  = '{6'h08, 32'hFFFF_FFFF, 6'h08, 32'h0000_0000, 32'h0000_0000};
      vecs[8]  = '{6'h07, 32'h0000_00FF, 6'h04, 32'h0000_00FF, 32'h0000_00FF};
      vecs[9]  = '{6'h24, 32'hFFFF_FFFF, 6'h24, 32'h0000_0000, 32'h0000_0000};
`ifdef GPIO_CTRL_GEN2_DEBOUNCE_EN
      vecs[10] = '{6'h20, 32'hFFFF_1234, 6'h20, 32'h0000_1234, 32'h0000_1234};
`else
      vecs[10] = '{6'h20, 32'hFFFF_1234, 6'h20, 32'h0000_0000, 32'h0000_0000};
`endif

      bus_idle();
      gpio_pin_in = 16'h0000;
      tse         = 16'h0000;
      p_reset     = 1'b1;
      repeat (2) @(negedge pclk);
      chk("rst_pin_out", 32'(pin_out), 32'h0000_0000);
      chk("rst_n_oe", 32'(n_oe), 32'h0000_FFFF);
      chk("rst_gpio_int", 32'(gpio_int), 32'h0000_0000);
      p_reset = 1'b0;

      // register table on both widths
      for (int i = 0; i < NVEC; i++) begin
         sb_push($sformatf("vec%0d_w16", i), vecs[i].exp16);
         sb_push($sformatf("vec%0d_w8", i), vecs[i].exp8);
         apb_write(vecs[i].wr_addr, vecs[i].wr_data);
         apb_read(vecs[i].rd_addr, r16, r8);
         sb_check(r16);
         sb_check(r8);
      end

      // DIN follows synchronised pins
      do_reset();
      gpio_pin_in = 16'h5A3C;
      repeat (40) @(negedge pclk);
      apb_read(6'h08, r16, r8);
      chk("din_w16", r16, 32'h0000_5A3C);
      chk("din_w8", r8, 32'h0000_003C);
      apb_read(6'h00, r16, r8);
      chk("dout_after_reset", r16, 32'h0000_0000);

      // output drive and tri-state override
      do_reset();
      apb_write(6'h04, 32'h0000_00FF);
      apb_write(6'h00, 32'h0000_A5A5);
      @(negedge pclk);
      chk("pin_out", 32'(pin_out), 32'h0000_A5A5);
      chk("n_oe", 32'(n_oe), 32'h0000_FF00);
      tse = 16'h0001;
      @(negedge pclk);
      chk("n_oe_tse", 32'(n_oe), 32'h0000_FF01);
      chk("n_oe_tse_w8", 32'(n_oe8), 32'h0000_0001);

      // reset asserted mid-access: outputs clear before any clock, write aborted
      @(negedge pclk);
      paddr   = 6'h00;
      pwdata  = 32'h0000_FFFF;
      pwrite  = 1'b1;
      psel    = 1'b1;
      @(negedge pclk);
      penable = 1'b1;
      #2;
      p_reset = 1'b1;
      #1;
      chk("async_rst_pin_out", 32'(pin_out), 32'h0000_0000);
      chk("async_rst_n_oe", 32'(n_oe), 32'h0000_FFFF);
      @(negedge pclk);
      bus_idle();
      p_reset = 1'b0;
      tse     = 16'h0000;
      apb_read(6'h00, r16, r8);
      chk("aborted_write", r16, 32'h0000_0000);

      // rising edge on pin3: ISTAT at edge LAT, gpio_int at edge LAT+1
      do_reset();
      apb_write(6'h10, 32'h0000_FFFF);
      apb_write(6'h14, 32'h0000_0008);
      apb_write(6'h18, 32'h0000_FFFF);
      apb_write(6'h0C, 32'h0000_0008);
      apb_read(6'h18, r16, r8);
      chk("istat_clear_before_edge", r16, 32'h0000_0000);
      chk("int_before_edge", 32'(gpio_int), 32'h0000_0000);
      @(negedge pclk);
      gpio_pin_in[3] = 1'b1;
      psel  = 1'b1;
      paddr = 6'h18;
      for (int k = 1; k <= LAT + 1; k++) begin
         @(negedge pclk);
         chk($sformatf("edge_istat_e%0d", k), prdata, (k >= LAT) ? 32'h0000_0008 : 32'h0000_0000);
         chk($sformatf("edge_int_e%0d", k), 32'(gpio_int), (k >= LAT + 1) ? 32'h0000_0001 : 32'h0000_0000);
      end
      bus_idle();
      apb_write(6'h18, 32'h0000_0008);
      @(negedge pclk);
      chk("int_after_w1c", 32'(gpio_int), 32'h0000_0000);
      apb_write(6'h14, 32'h0000_FFFF);
      apb_read(6'h18, r16, r8);
      chk("ipol_change_no_set", r16, 32'h0000_0000);

      // level mode, active low, pins low: W1C cannot clear the bit
      do_reset();
      apb_write(6'h0C, 32'h0000_0001);
      @(negedge pclk);
      chk("level_int", 32'(gpio_int), 32'h0000_0001);
      apb_write(6'h18, 32'h0000_0001);
      chk("level_int_w1c_e0", 32'(gpio_int), 32'h0000_0001);
      @(negedge pclk);
      chk("level_int_w1c_e1", 32'(gpio_int), 32'h0000_0001);
      apb_read(6'h18, r16, r8);
      chk("level_istat", r16, 32'h0000_FFFF);

      // edge event on the same edge as a W1C of that bit
      do_reset();
      apb_write(6'h10, 32'h0000_FFFF);
      apb_write(6'h14, 32'h0000_0020);
      apb_write(6'h18, 32'h0000_FFFF);
      @(negedge pclk);
      gpio_pin_in[5] = 1'b1;
      paddr   = 6'h18;
      pwdata  = 32'h0000_0020;
      pwrite  = 1'b1;
      psel    = 1'b1;
      repeat (LAT - 1) @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      bus_idle();
      apb_read(6'h18, r16, r8);
      chk("set_beats_clear", r16, 32'h0000_0020);
      chk("latched_with_ien0_int", 32'(gpio_int), 32'h0000_0000);
      apb_write(6'h18, 32'h0000_0020);
      apb_read(6'h18, r16, r8);
      chk("w1c_no_event", r16, 32'h0000_0000);

      // both-edge (pin1) versus falling-only (pin4)
      do_reset();
      apb_write(6'h10, 32'h0000_FFFF);
      apb_write(6'h1C, 32'h0000_0002);
      apb_write(6'h18, 32'h0000_FFFF);
      @(negedge pclk);
      gpio_pin_in = 16'h0012;
      repeat (LAT + 2) @(negedge pclk);
      apb_read(6'h18, r16, r8);
      chk("rise_both_vs_fall", r16, 32'h0000_0002);
      apb_write(6'h18, 32'h0000_FFFF);
      gpio_pin_in = 16'h0000;
      repeat (LAT + 2) @(negedge pclk);
      apb_read(6'h18, r16, r8);
      chk("fall_both_and_fall", r16, 32'h0000_0012);

`ifdef GPIO_CTRL_GEN2_DEBOUNCE_EN
      // debounce: 3-cycle glitch filtered, sustained level passes
      do_reset();
      apb_write(6'h20, 32'h0000_0001);
      @(negedge pclk);
      gpio_pin_in[2] = 1'b1;
      psel  = 1'b1;
      paddr = 6'h08;
      for (int k = 1; k <= 10; k++) begin
         @(negedge pclk);
         if (k == 3) begin
            gpio_pin_in[2] = 1'b0;
         end
         chk($sformatf("deb_glitch_c%0d", k), prdata, 32'h0000_0000);
      end
      gpio_pin_in[2] = 1'b1;
      repeat (14) @(negedge pclk);
      chk("deb_held_w16", prdata, 32'h0000_0004);
      chk("deb_held_w8", prdata8, 32'h0000_0004);
      bus_idle();
`endif

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpio_ctrl_gen2.md
GPIO_CTRL_GEN2 -- requirements
Module: gpio_ctrl_gen2

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning pin count; legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning input synchroniser depth; legal range 2..4.
REQ-003 SHALL have port pclk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port p_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports psel, penable and pwrite, input, 1 bit each: APB control.
REQ-006 SHALL have port paddr, input, 6 bits: word address, bits [1:0] ignored.
REQ-007 SHALL have port pwdata, input, 32 bits: write data.
REQ-008 SHALL have port prdata, output, 32 bits: read data.
REQ-009 SHALL have port gpio_pin_in, input, WIDTH bits: asynchronous pin inputs.
REQ-010 SHALL have port tri_state_enable, input, WIDTH bits: DFT override that forces the output driver off.
REQ-011 SHALL have ports gpio_pin_out and n_gpio_pin_oe, output, WIDTH bits each: pin drive value and active-low output enable.
REQ-012 SHALL have port gpio_int, output, 1 bit: registered interrupt.

Function
REQ-013 SHALL use this register map: 0x00 DOUT RW, 0x04 DIR RW (1 = output), 0x08 DIN RO, 0x0C IEN RW, 0x10 ITYPE RW (1 = edge, 0 = level), 0x14 IPOL RW, 0x18 ISTAT RW1C, 0x1C IBOTH RW.
REQ-014 SHALL perform a write when psel, penable and pwrite are all 1; the register updates on that clock edge.
REQ-015 SHALL drive prdata combinationally when psel=1 and pwrite=0, and drive 0 otherwise.
REQ-016 SHALL read bits at or above WIDTH and all unmapped offsets as 0, and SHALL ignore writes to them.
REQ-017 SHALL drive gpio_pin_out = DOUT and n_gpio_pin_oe = ~(DIR & ~tri_state_enable).
REQ-018 SHALL pass each pin through SYNC_STAGES flops; DIN SHALL return the synchronised value.
REQ-019 SHALL register the synchronised value as prev; the edge event is sync != prev.
REQ-020 SHALL, in edge mode, set ISTAT[i] on a rising edge if IPOL[i]=1, on a falling edge if IPOL[i]=0, and on either edge if IBOTH[i]=1.
REQ-021 SHALL, in level mode, set ISTAT[i] every cycle that sync[i]==IPOL[i].
REQ-022 SHALL, on a same-cycle set and W1C clear, give set priority; a level source still active re-sets its bit on the next cycle.
REQ-023 SHALL register gpio_int as |(ISTAT & IEN).
REQ-024 SHALL meet this latency: pin change settled before edge 1 -> ISTAT set at edge SYNC_STAGES+1 -> gpio_int set at edge SYNC_STAGES+2.
REQ-025 SHALL NOT set ISTAT for an ITYPE/IPOL change alone; ISTAT bits still latch when IEN=0.

Reset
REQ-026 SHALL, on p_reset=1 and without waiting for a clock, clear DOUT, DIR, IEN, ITYPE, IPOL, IBOTH, ISTAT, the sync flops, prev and gpio_int; gpio_pin_out SHALL then be 0 and n_gpio_pin_oe all ones.
REQ-027 SHALL, when reset asserts during an APB access, abort the access; no register is written.
REQ-028 SHALL NOT flag a spurious edge in the first cycles after reset deassertion, because prev and sync both start at 0.

Configuration
REQ-029 SHALL, with macro GPIO_CTRL_GEN2_DEBOUNCE_EN defined, add register 0x20 DBPRE RW (16 bits, reset 0) and a per-pin debounce stage after the synchroniser.
REQ-030 SHALL implement debounce as follows: a shared prescaler ticks every DBPRE+1 cycles; the filtered pin takes the synchronised value after 3 consecutive equal samples taken on ticks.
REQ-031 SHALL feed DIN and edge detection from the filtered value, which adds latency.
REQ-032 SHALL, without the macro, omit 0x20 (reads 0) and take DIN and edges directly from the synchroniser.

Structure
REQ-033 SHALL place register offsets, reset values and the debounce sample count (3) in package gpio_ctrl_gen2_pkg.
REQ-034 SHALL implement the per-pin debounce as sub-module gpio_ctrl_gen2_deb, instantiated WIDTH times, and only when the macro is defined.

Verification
REQ-035 SHALL check: write DIR=0x00FF, DOUT=0xA5A5 -> gpio_pin_out=0xA5A5 and n_gpio_pin_oe=0xFF00; then tri_state_enable=0x0001 -> n_gpio_pin_oe=0xFF01.
REQ-036 SHALL check: ITYPE[3]=1, IPOL[3]=1, IEN[3]=1, pin3 0->1 -> ISTAT=0x0008 at edge 3 and gpio_int=1 at edge 4 (SYNC_STAGES=2); W1C 0x0008 -> gpio_int=0 next cycle.
REQ-037 SHALL check: level mode with IPOL[0]=0, pin0 held low, W1C ISTAT[0] -> the bit re-sets the next cycle and gpio_int stays 1.
REQ-038 SHALL check: edge event coinciding with a W1C of the same bit -> the bit stays 1.
REQ-039 SHALL check: WIDTH=8, read 0x00 after writing 0xFFFFFFFF -> 0x000000FF; read 0x3C -> 0.
REQ-040 SHALL check, with the macro defined: DBPRE=1 and a 3-cycle glitch on pin2 -> DIN[2] unchanged; a level held for 6 ticks -> DIN[2] updates.
